// File: rtl/prandom_arb.sv
// prandom_arb: two-requester round-robin arbiter handing out values from a
// 3-bit maximal-length LFSR (x^3+x^2+1, period 7, never 3'b000).
// Each grant walks IDLE -> STEP -> ACK -> (GAPW) -> IDLE. A single
// registered ack pulse carries the freshly advanced value on Q.
//
// Optional feature: define PRANDOM_SEED_EN to add the seed_we/seed ports,
// which reload the LFSR in any state. A seed of 3'b000 loads as 3'b001.
//
// RESET_STATE must be non-zero; an all-zero LFSR would lock up.
module prandom_arb #(
  parameter logic [2:0]  RESET_STATE = 3'b001,
  parameter int unsigned GAP         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
`ifdef PRANDOM_SEED_EN
  input  logic       seed_we,
  input  logic [2:0] seed,
`endif
  output logic       ack0,
  output logic       ack1,
  output logic [2:0] Q,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ACK  = 2'd2,
    GAPW = 2'd3
  } state_t;

  // Last GAPW count before returning to IDLE; unused when GAP is 0.
  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] lfsr, lfsr_nxt;
  logic [2:0] lfsr_stepped;
  logic [2:0] gap_cnt, gap_cnt_nxt;
  logic [2:0] q_nxt;
  logic       ack0_nxt, ack1_nxt;
  logic       winner, winner_nxt;   // 0 = requester 0, 1 = requester 1
  logic       last, last_nxt;       // requester served most recently

`ifdef PRANDOM_SEED_EN
  logic [2:0] seed_fixed;
  // The all-zero state is a lock-up state of the LFSR, so it is remapped.
  assign seed_fixed = (seed == 3'b000) ? 3'b001 : seed;
`endif

  assign lfsr_stepped = {lfsr[1:0], lfsr[2] ^ lfsr[1]};
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = STEP;
      STEP:    state_nxt = ACK;
      ACK:     state_nxt = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values: winner latch, LFSR step, ack/Q, pointer.
  always_comb begin
    lfsr_nxt    = lfsr;
    q_nxt       = Q;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    winner_nxt  = winner;
    last_nxt    = last;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (req0 || req1) winner_nxt = (req0 && req1) ? ~last : req1;
      end
      STEP: begin
        lfsr_nxt = lfsr_stepped;
        q_nxt    = lfsr_stepped;
        ack0_nxt = ~winner;
        ack1_nxt = winner;
      end
      ACK: begin
        last_nxt    = winner;
        gap_cnt_nxt = 3'd0;
      end
      GAPW: gap_cnt_nxt = gap_cnt + 3'd1;
      default: ;
    endcase
`ifdef PRANDOM_SEED_EN
    // A seed load overrides the step; the ack then carries the seed itself.
    if (seed_we) begin
      lfsr_nxt = seed_fixed;
      if (state == STEP) q_nxt = seed_fixed;
    end
`endif
  end

  // Registered outputs and datapath; reset drops any latched winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= RESET_STATE;
      Q       <= 3'b000;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      winner  <= 1'b0;
      last    <= 1'b1;
      gap_cnt <= 3'd0;
    end else begin
      lfsr    <= lfsr_nxt;
      Q       <= q_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      winner  <= winner_nxt;
      last    <= last_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prandom_arb.sv
// Testbench for prandom_arb. Two instances share clock and reset:
// dut_a with GAP=0 and dut_b with GAP=2. The reference model tracks the
// LFSR as a position in the published period-7 output sequence and the
// arbitration pointer as "who was served last".
module tb_prandom_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_a, req1_a, ack0_a, ack1_a, busy_a;
  logic       req0_b, req1_b, ack0_b, ack1_b, busy_b;
  logic [2:0] q_a, q_b;
`ifdef PRANDOM_SEED_EN
  logic       seed_we;
  logic [2:0] seed;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [2:0] seq_tbl [7];
  int         m_idx;     // dut_a: index of current LFSR value in seq_tbl
  logic       m_last;    // dut_a: requester served last
  int         b_idx;     // dut_b: index of current LFSR value

  always #5 clk = ~clk;

  prandom_arb #(.RESET_STATE(3'b001), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .req0(req0_a), .req1(req1_a),
`ifdef PRANDOM_SEED_EN
    .seed_we(seed_we), .seed(seed),
`endif
    .ack0(ack0_a), .ack1(ack1_a), .Q(q_a), .busy(busy_a)
  );

  prandom_arb #(.RESET_STATE(3'b001), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
`ifdef PRANDOM_SEED_EN
    .seed_we(1'b0), .seed(3'b000),
`endif
    .ack0(ack0_b), .ack1(ack1_b), .Q(q_b), .busy(busy_b)
  );

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 7; i++) if (seq_tbl[i] == v) return i;
    return 0;
  endfunction

  // Reset both instances and the model (value 3'b001 sits at index 6).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_idx = 6; m_last = 1'b1; b_idx = 6;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ack0_a, ack1_a, busy_a, q_a} !== 6'b0) begin
      failures++;
      $display("FAIL reset_a got ack0=%b ack1=%b busy=%b Q=%b want 0 0 0 000", ack0_a, ack1_a, busy_a, q_a);
    end
    checks++;
    if ({ack0_b, ack1_b, busy_b, q_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_b got ack0=%b ack1=%b busy=%b Q=%b want 0 0 0 000", ack0_b, ack1_b, busy_b, q_b);
    end
    @(negedge clk);
    rst = 1'b0;
    m_idx = 6; m_last = 1'b1; b_idx = 6;
    @(negedge clk);
    checks++;
    if ({ack0_a, ack1_a, busy_a, q_a} !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle got ack0=%b ack1=%b busy=%b Q=%b want 0 0 0 000", ack0_a, ack1_a, busy_a, q_a);
    end
  endtask

  task automatic test_single_req0();
    do_reset();
    req0_a = 1'b1;
    @(negedge clk);
    checks++;
    if (ack0_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL single_step got ack0=%b busy=%b want 0 1", ack0_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (ack0_a !== 1'b1 || ack1_a !== 1'b0 || q_a !== 3'b010) begin
      failures++;
      $display("FAIL single_ack got ack0=%b ack1=%b Q=%b want 1 0 010", ack0_a, ack1_a, q_a);
    end
    req0_a = 1'b0;
    m_idx = 0; m_last = 1'b0;
    @(negedge clk);
    checks++;
    if (ack0_a !== 1'b0 || busy_a !== 1'b0 || q_a !== 3'b010) begin
      failures++;
      $display("FAIL single_after got ack0=%b busy=%b Q=%b want 0 0 010", ack0_a, busy_a, q_a);
    end
  endtask

  task automatic test_alternate();
    logic       exp_w;
    logic [2:0] exp_q;
    do_reset();
    req0_a = 1'b1; req1_a = 1'b1;
    for (int g = 0; g < 14; g++) begin
      exp_w = ~m_last;
      exp_q = seq_tbl[(m_idx + 1) % 7];
      @(negedge clk);
      checks++;
      if (ack0_a !== 1'b0 || ack1_a !== 1'b0) begin
        failures++;
        $display("FAIL alt_gap%0d got ack0=%b ack1=%b want 0 0", g, ack0_a, ack1_a);
      end
      @(negedge clk);
      checks++;
      if (ack0_a !== ~exp_w || ack1_a !== exp_w || q_a !== exp_q) begin
        failures++;
        $display("FAIL alt_grant%0d got ack0=%b ack1=%b Q=%b want %b %b %b", g, ack0_a, ack1_a, q_a, ~exp_w, exp_w, exp_q);
      end
      m_idx = (m_idx + 1) % 7; m_last = exp_w;
      @(negedge clk);
    end
    req0_a = 1'b0; req1_a = 1'b0;
  endtask

  task automatic test_gap();
    logic exp_ack, exp_busy;
    do_reset();
    req1_b = 1'b1;
    for (int k = 0; k < 15; k++) begin
      exp_ack  = (k % 5 == 1);
      exp_busy = (k % 5 != 4);
      @(negedge clk);
      checks++;
      if (ack1_b !== exp_ack || busy_b !== exp_busy || ack0_b !== 1'b0) begin
        failures++;
        $display("FAIL gap_cycle%0d got ack1=%b busy=%b ack0=%b want %b %b 0", k, ack1_b, busy_b, ack0_b, exp_ack, exp_busy);
      end
      if (exp_ack) begin
        checks++;
        if (q_b !== seq_tbl[(b_idx + 1) % 7]) begin
          failures++;
          $display("FAIL gap_q%0d got Q=%b want %b", k, q_b, seq_tbl[(b_idx + 1) % 7]);
        end
        b_idx = (b_idx + 1) % 7;
      end
    end
    req1_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_a = 1'b1;
    repeat (2) @(negedge clk);
    req0_a = 1'b0;
    @(negedge clk);
    req1_a = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || q_a !== 3'b010) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b Q=%b want 1 010", busy_a, q_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ack0_a, ack1_a, busy_a, q_a} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_now got ack0=%b ack1=%b busy=%b Q=%b want 0 0 0 000", ack0_a, ack1_a, busy_a, q_a);
    end
    @(negedge clk);
    checks++;
    if (ack0_a !== 1'b0 || ack1_a !== 1'b0) begin
      failures++;
      $display("FAIL midrst_noack got ack0=%b ack1=%b want 0 0", ack0_a, ack1_a);
    end
    rst = 1'b0; req1_a = 1'b0;
    m_idx = 6; m_last = 1'b1; b_idx = 6;
    @(negedge clk);
    req0_a = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack0_a !== 1'b1 || ack1_a !== 1'b0 || q_a !== 3'b010) begin
      failures++;
      $display("FAIL midrst_after got ack0=%b ack1=%b Q=%b want 1 0 010", ack0_a, ack1_a, q_a);
    end
    req0_a = 1'b0;
    m_idx = 0; m_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic       p0, p1, exp_w;
    logic [2:0] exp_q;
    do_reset();
    p0 = 1'b0; p1 = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (!p0 && $urandom_range(0, 1) == 1) p0 = 1'b1;
      if (!p1 && $urandom_range(0, 1) == 1) p1 = 1'b1;
      req0_a = p0; req1_a = p1;
      if (!p0 && !p1) begin
        @(negedge clk);
        checks++;
        if (ack0_a !== 1'b0 || ack1_a !== 1'b0 || busy_a !== 1'b0) begin
          failures++;
          $display("FAIL rnd_idle%0d got ack0=%b ack1=%b busy=%b want 0 0 0", r, ack0_a, ack1_a, busy_a);
        end
        continue;
      end
      exp_w = (p0 && p1) ? ~m_last : p1;
      exp_q = seq_tbl[(m_idx + 1) % 7];
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || ack0_a !== 1'b0 || ack1_a !== 1'b0) begin
        failures++;
        $display("FAIL rnd_step%0d got busy=%b ack0=%b ack1=%b want 1 0 0", r, busy_a, ack0_a, ack1_a);
      end
      @(negedge clk);
      checks++;
      if (ack0_a !== ~exp_w || ack1_a !== exp_w || q_a !== exp_q) begin
        failures++;
        $display("FAIL rnd_grant%0d got ack0=%b ack1=%b Q=%b want %b %b %b", r, ack0_a, ack1_a, q_a, ~exp_w, exp_w, exp_q);
      end
      if (exp_w) p1 = 1'b0; else p0 = 1'b0;
      req0_a = p0; req1_a = p1;
      m_idx = (m_idx + 1) % 7; m_last = exp_w;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || ack0_a !== 1'b0 || ack1_a !== 1'b0 || q_a !== exp_q) begin
        failures++;
        $display("FAIL rnd_hold%0d got busy=%b ack0=%b ack1=%b Q=%b want 0 0 0 %b", r, busy_a, ack0_a, ack1_a, q_a, exp_q);
      end
    end
    req0_a = 1'b0; req1_a = 1'b0;
    @(negedge clk);
  endtask

`ifdef PRANDOM_SEED_EN
  task automatic test_seed();
    do_reset();
    seed_we = 1'b1; seed = 3'b000;
    @(negedge clk);
    seed_we = 1'b0;
    m_idx = idx_of(3'b001);
    req1_a = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack1_a !== 1'b1 || q_a !== seq_tbl[(m_idx + 1) % 7]) begin
      failures++;
      $display("FAIL seed_zero got ack1=%b Q=%b want 1 %b", ack1_a, q_a, seq_tbl[(m_idx + 1) % 7]);
    end
    req1_a = 1'b0;
    m_idx = (m_idx + 1) % 7;
    @(negedge clk);
    req0_a = 1'b1;
    @(negedge clk);
    seed_we = 1'b1; seed = 3'b100;
    @(negedge clk);
    seed_we = 1'b0;
    checks++;
    if (ack0_a !== 1'b1 || q_a !== 3'b100) begin
      failures++;
      $display("FAIL seed_step got ack0=%b Q=%b want 1 100", ack0_a, q_a);
    end
    req0_a = 1'b0;
    m_idx = idx_of(3'b100);
    @(negedge clk);
    req0_a = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack0_a !== 1'b1 || q_a !== seq_tbl[(m_idx + 1) % 7]) begin
      failures++;
      $display("FAIL seed_next got ack0=%b Q=%b want 1 %b", ack0_a, q_a, seq_tbl[(m_idx + 1) % 7]);
    end
    req0_a = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    seq_tbl[0] = 3'b010; seq_tbl[1] = 3'b101; seq_tbl[2] = 3'b011;
    seq_tbl[3] = 3'b111; seq_tbl[4] = 3'b110; seq_tbl[5] = 3'b100;
    seq_tbl[6] = 3'b001;
    rst = 1'b0;
    req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
`ifdef PRANDOM_SEED_EN
    seed_we = 1'b0; seed = 3'b000;
`endif
    test_reset();
    test_single_req0();
    test_alternate();
    test_gap();
    test_reset_mid();
    test_random();
`ifdef PRANDOM_SEED_EN
    test_seed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
